change_dispenser: RTL
=====================

# change_dispenser

Coin-dispensing back end for the vending machine: accepts one refund amount (in 1,000-won units) and pays it out to the coin hopper one coin per handshake. It is the payout counterpart of the coin-acceptor side and uses the same 2-bit coin code the machine uses on its inputs. Selection is greedy: a 5,000-won coin whenever the remainder and inventory allow it, otherwise a 1,000-won coin. Payouts that inventory cannot cover are reported as a shortfall.

## Interface
- MAX_UNITS, 20: largest legal refund request in 1,000-won units (20,000 won).
- INV_W, 6: width of each coin inventory counter.
- INIT_5K, 8: 5,000-won coin count loaded at reset.
- INIT_1K, 20: 1,000-won coin count loaded at reset.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  refund request present.
- req_amount  in  5  refund amount in 1,000-won units.
- req_ready  out  1  block can accept a request (IDLE only).
- coin_out  out  2  coin presented to the hopper: 00 none, 01 1,000 won, 10 5,000 won; 11 never driven.
- coin_valid  out  1  coin_out is valid.
- coin_ack  in  1  hopper has taken the presented coin.
- refill_5k  in  1  one-cycle pulse: one 5,000-won coin added to inventory.
- refill_1k  in  1  one-cycle pulse: one 1,000-won coin added to inventory.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse at request completion.
- err  out  1  valid with done: request was over-range or not fully paid.
- short_fall  out  5  unpaid units; valid with done.
- inv_5k, inv_1k  out  INV_W  current inventory counts.

## Operation
- **States:** IDLE, SELECT, PRESENT, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch req_amount into remaining.
  - If req_amount > MAX_UNITS, go to DONE with err=1, short_fall=req_amount, and dispense no coins.
  - Otherwise go to SELECT.
- **SELECT (one cycle):**
  - If remaining ≥ 5 and inv_5k > 0, register code 10 and go to PRESENT.
  - Else if remaining ≥ 1 and inv_1k > 0, register code 01 and go to PRESENT.
  - Else if remaining == 0, go to DONE with err=0.
  - Else go to DONE with err=1 and short_fall=remaining.
- **PRESENT:**
  - coin_valid=1; coin_out stays stable until coin_ack.
  - On coin_ack, subtract 5 or 1 from remaining, decrement the matching inventory counter, and go to SELECT.
- **DONE:** done=1 for one cycle, then IDLE.
- **busy:** 1 in SELECT, PRESENT and DONE.
- **Inventory:**
  - A refill saturates the counter at 2^INV_W−1.
  - A refill and a dispense of the same denomination in the same cycle leave the count unchanged.
  - Refills are accepted in every state.
- **Ignored inputs:**
  - coin_ack outside PRESENT.
  - req_valid outside IDLE.
- **Reset values:**
  - State IDLE, req_ready=1.
  - coin_valid=0, coin_out=00, busy=0, done=0, err=0, short_fall=0.
  - inv_5k=INIT_5K, inv_1k=INIT_1K.
- **Reset mid-payout:** aborts the request. No done pulse; inventory reloads to its INIT values.

## Timing
- A request accepted at edge N gives SELECT in cycle N+1 and coin_valid from N+2.
- With coin_ack tied high, one coin is paid every 2 cycles.
- A request of amount 0 produces done at N+2.
- An over-range request produces done at N+1.
- err and short_fall hold their values from the done cycle until the next request is accepted.

## Configuration
- **CHANGE_DISPENSER_INV_EN defined:**
  - Inventory counters, refill inputs and shortfall detection are present.
  - Denominations with zero coins are skipped.
- **CHANGE_DISPENSER_INV_EN undefined:**
  - Inventory is treated as unlimited; inv_5k and inv_1k read 0 and refill inputs are ignored.
  - err is raised only for over-range requests; short_fall is 0 otherwise.

## Structure
- **Shared package vm_pkg holds:**
  - Coin codes COIN_NONE, COIN_1K, COIN_5K.
  - PRICE_UNITS=10, MAX_UNITS=20.
  - The dispenser state enum.
- **Sub-module coin_inventory:** two saturating up/down counters with refill and dispense strobes. It is compiled in only under CHANGE_DISPENSER_INV_EN.

## Test plan
- Amount 3 with default inventory -> coin_out 01, 01, 01; done with err=0; inv_1k 20→17.
- Amount 8 -> coin_out 10, 01, 01, 01; done with err=0; inv_5k 8→7, inv_1k 20→17.
- Amount 8 with inv_5k forced to 0 by preloading via reset parameters -> eight 01 coins; err=0.
- INIT_1K=2, INIT_5K=0, amount 3 -> two 01 coins, then done with err=1, short_fall=1.
- Amount 25 -> no coin_valid; done at N+1 with err=1, short_fall=25. Amount 0 -> done at N+2 with err=0.
- Further cases:
  - coin_ack held low for 4 cycles -> coin_out and coin_valid stable throughout.
  - refill_1k pulsed in the same cycle as a 1K dispense ack -> inv_1k unchanged.
  - rst asserted during PRESENT -> coin_valid=0 next cycle, inventory back to INIT values, no done.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, refund range limits and
// the change dispenser state encoding.
package vm_pkg;

  localparam int unsigned PRICE_UNITS = 10;
  localparam int unsigned MAX_UNITS   = 20;
  localparam int unsigned AMT_W       = 5;
  localparam int unsigned COIN_W      = 2;

  // 2-bit coin code shared with the coin-acceptor side; 2'b11 is never used
  typedef enum logic [COIN_W-1:0] {
    COIN_NONE = 2'b00,
    COIN_1K   = 2'b01,
    COIN_5K   = 2'b10
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SELECT  = 2'b01,
    ST_PRESENT = 2'b10,
    ST_DONE    = 2'b11
  } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Request and hopper handshake bundle for the change dispenser.
//   req_valid/req_amount/req_ready : refund request handshake
//   coin_out/coin_valid/coin_ack   : one coin per handshake to the hopper
// master = requester/hopper side, slave = dispenser.
interface change_dispenser_if;
  import vm_pkg::*;

  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  coin_e            coin_out;
  logic             coin_valid;
  logic             coin_ack;

  modport master (
    output req_valid, req_amount, coin_ack,
    input  req_ready, coin_out, coin_valid
  );

  modport slave (
    input  req_valid, req_amount, coin_ack,
    output req_ready, coin_out, coin_valid
  );
endinterface

// File: rtl/coin_inventory.sv
// Two saturating coin counters (5,000 and 1,000 won) with refill and
// dispense strobes. Only built when CHANGE_DISPENSER_INV_EN is defined.
// Ports: clk, rst (sync, active high), refill_5k/refill_1k (+1),
//        disp_5k/disp_1k (-1), count_5k/count_1k (registered counts).
`ifdef CHANGE_DISPENSER_INV_EN
module coin_inventory #(
  parameter int unsigned INV_W   = 6,
  parameter int unsigned INIT_5K = 8,
  parameter int unsigned INIT_1K = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill_5k,
  input  logic             refill_1k,
  input  logic             disp_5k,
  input  logic             disp_1k,
  output logic [INV_W-1:0] count_5k,
  output logic [INV_W-1:0] count_1k
);

  localparam logic [INV_W-1:0] CNT_MAX = {INV_W{1'b1}};

  // Simultaneous refill and dispense cancel out; otherwise saturate both ways
  function automatic logic [INV_W-1:0] step(input logic [INV_W-1:0] cnt,
                                            input logic up, input logic dn);
    logic [INV_W-1:0] nxt;
    nxt = cnt;
    if (up && !dn && (cnt != CNT_MAX)) nxt = cnt + INV_W'(1);
    if (dn && !up && (cnt != '0))      nxt = cnt - INV_W'(1);
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count_5k <= INV_W'(INIT_5K);
      count_1k <= INV_W'(INIT_1K);
    end else begin
      count_5k <= step(count_5k, refill_5k, disp_5k);
      count_1k <= step(count_1k, refill_1k, disp_1k);
    end
  end

endmodule
`endif

// File: rtl/change_dispenser.sv
// Refund payout engine: takes one refund amount (1,000-won units) and pays
// it to the hopper one coin per handshake, greedily preferring 5,000-won
// coins. Optional inventory tracking under CHANGE_DISPENSER_INV_EN.
// Ports: clk, rst (sync, active high), bus (change_dispenser_if.slave),
//        refill_5k/refill_1k pulses, busy, done pulse, err/short_fall
//        (valid with done, held until next accept), inv_5k/inv_1k counts.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned INV_W   = 6,
  parameter int unsigned INIT_5K = 8,
  parameter int unsigned INIT_1K = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  change_dispenser_if.slave    bus,
  input  logic                 refill_5k,
  input  logic                 refill_1k,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AMT_W-1:0]     short_fall,
  output logic [INV_W-1:0]     inv_5k,
  output logic [INV_W-1:0]     inv_1k
);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  coin_e            coin_sel_q, coin_sel_d;
  logic             err_d;
  logic [AMT_W-1:0] short_fall_d;
  logic             have_5k, have_1k;
  logic             disp_5k, disp_1k;

  logic  req_ready_q, req_ready_d;
  logic  coin_valid_q, coin_valid_d;
  coin_e coin_out_q, coin_out_d;
  logic  busy_d, done_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_sel_q   <= COIN_NONE;
      req_ready_q  <= 1'b1;
      coin_valid_q <= 1'b0;
      coin_out_q   <= COIN_NONE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      short_fall   <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_sel_q   <= coin_sel_d;
      req_ready_q  <= req_ready_d;
      coin_valid_q <= coin_valid_d;
      coin_out_q   <= coin_out_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      short_fall   <= short_fall_d;
    end
  end

  // Next state, remaining amount, coin choice and completion status
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_sel_d   = coin_sel_q;
    err_d        = err;
    short_fall_d = short_fall;
    disp_5k      = 1'b0;
    disp_1k      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          remaining_d  = bus.req_amount;
          err_d        = 1'b0;
          short_fall_d = '0;
          if (bus.req_amount > AMT_W'(MAX_UNITS)) begin
            // Over-range: report the full amount unpaid, dispense nothing
            state_d      = ST_DONE;
            err_d        = 1'b1;
            short_fall_d = bus.req_amount;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        if ((remaining_q >= AMT_W'(5)) && have_5k) begin
          coin_sel_d = COIN_5K;
          state_d    = ST_PRESENT;
        end else if ((remaining_q != '0) && have_1k) begin
          coin_sel_d = COIN_1K;
          state_d    = ST_PRESENT;
        end else if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_DONE;
          err_d        = 1'b1;
          short_fall_d = remaining_q;
        end
      end
      ST_PRESENT: begin
        if (bus.coin_ack) begin
          state_d = ST_SELECT;
          if (coin_sel_q == COIN_5K) begin
            remaining_d = remaining_q - AMT_W'(5);
            disp_5k     = 1'b1;
          end else begin
            remaining_d = remaining_q - AMT_W'(1);
            disp_1k     = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs register with it
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    coin_valid_d = (state_d == ST_PRESENT);
    coin_out_d   = (state_d == ST_PRESENT) ? coin_sel_d : COIN_NONE;
    done_d       = (state_d == ST_DONE);
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_out   = coin_out_q;

`ifdef CHANGE_DISPENSER_INV_EN
  logic [INV_W-1:0] cnt_5k, cnt_1k;

  coin_inventory #(
    .INV_W   (INV_W),
    .INIT_5K (INIT_5K),
    .INIT_1K (INIT_1K)
  ) u_inventory (
    .clk       (clk),
    .rst       (rst),
    .refill_5k (refill_5k),
    .refill_1k (refill_1k),
    .disp_5k   (disp_5k),
    .disp_1k   (disp_1k),
    .count_5k  (cnt_5k),
    .count_1k  (cnt_1k)
  );

  assign have_5k = (cnt_5k != '0);
  assign have_1k = (cnt_1k != '0);
  assign inv_5k  = cnt_5k;
  assign inv_1k  = cnt_1k;
`else
  // Unlimited inventory: counts read zero, refills and strobes are dropped
  localparam int unsigned unused_init = INIT_5K + INIT_1K;
  logic unused_inv;
  assign unused_inv = ^{refill_5k, refill_1k, disp_5k, disp_1k};
  assign have_5k    = 1'b1;
  assign have_1k    = 1'b1;
  assign inv_5k     = '0;
  assign inv_1k     = '0;
`endif

endmodule
